traffic_gen_stream: RTL and testbench
=====================================

// Module: traffic_gen_stream
// PURPOSE
//   Single-lane 14-bit AXI-Stream traffic generator. Instantiated four per output stream, upstream of
//   the lane aligner/FIFO stage, which packs four lanes into one 128-bit word and drives the counter monitor.
//   Produces ramp/constant/LFSR/alternating patterns with programmable inter-sample gap and burst length.
// PARAMETERS
//   DATA_WIDTH  14          sample width; pattern arithmetic is mod 2^DATA_WIDTH
//   INIT_VALUE  14'h0000    first sample for ramp/constant/alternating modes
//   LFSR_SEED   14'h0001    first sample for LFSR mode; 0 is replaced by 14'h0001
//   BURST_LEN   32'd1024    samples per burst; 0 = unbounded (run until stopped)
// PORTS
//   aclk             in   1           clock, all logic rising-edge
//   reset            in   1           synchronous, active-high
//   command          in   32          [0] run, [6] soft reset, [8:7] mode, [23:16] gap cycles
//   M00_AXIS_TVALID  out  1           sample valid
//   M00_AXIS_TDATA   out  DATA_WIDTH  sample
//   M00_AXIS_TREADY  in   1           downstream ready
//   sample_count     out  32          handshakes completed in current/last burst
//   busy             out  1           state is SEND or GAP
//   done             out  1           state is DONE
// BEHAVIOUR
// - Reset (reset=1 or command[6]=1): state IDLE, TVALID=0, TDATA=0, sample_count=0, busy=0, done=0,
//   run-edge register cleared. Reset mid-burst: TVALID drops in the cycle after reset is sampled.
// - start = command[0] rising edge (registered previous value). stop = command[0]==0.
// - Modes: 00 ramp (+1, wraps 3FFF->0000), 01 constant, 10 LFSR, 11 alternating (data <= ~data).
// - LFSR: next = {d[12:0], d13^d12^d11^d1}; maximal-length 14-bit.
// - mode and gap latched on start; later command changes ignored until next start.
// - FSM IDLE/SEND/GAP/DONE:
//   IDLE: TVALID=0. On start: load TDATA (INIT_VALUE or seed), sample_count=0 -> SEND.
//         TVALID=1 in cycle after start edge is sampled (1-cycle latency).
//   SEND: TVALID=1. TDATA/TVALID stable while TREADY=0 (AXI rule; stop does not withdraw TVALID).
//         On handshake: sample_count+1, advance pattern, then in priority order:
//         (count+1)==BURST_LEN -> DONE; stop -> IDLE; gap!=0 -> GAP, gap_cnt=gap; else stay SEND.
//         gap=0 with TREADY=1 gives one sample per cycle.
//   GAP:  TVALID=0, gap_cnt decrements; at gap_cnt==1 -> SEND (exactly gap idle cycles).
//         stop -> IDLE.
//   DONE: TVALID=0, done=1; command[0]==0 -> IDLE. A new burst needs a fresh rising edge.
// - sample_count saturates at 32'hFFFF_FFFF (matters only with BURST_LEN=0). Holds its value in IDLE/DONE.
// - TDATA in IDLE/DONE holds the last advanced value; it is a don't-care while TVALID=0.
// CONFIGURATION
// - TRAFFIC_GEN_TLAST_EN defined: adds output M00_AXIS_TLAST (1 bit, reset 0).
//   TLAST=1 with the final sample of a burst (count+1==BURST_LEN); held with TDATA under backpressure.
//   TLAST is always 0 when BURST_LEN=0.
// - Not defined: no TLAST port; behaviour otherwise identical.
// TESTING
// - Ramp, INIT 0, BURST_LEN 4, gap 0, TREADY=1, run rises -> TDATA 0,1,2,3 on 4 consecutive cycles,
//   then done=1, sample_count=4, TVALID=0.
// - Backpressure: TREADY=0 for 3 cycles during sample 2 -> TVALID=1 and TDATA=2 stable; count stalls.
// - gap=2, ramp -> TVALID pattern 1,0,0,1,0,0...; each sample accepted only on the TVALID=1 cycles.
// - INIT 3FFE, ramp -> 3FFE,3FFF,0000. LFSR, seed 0001 -> 0001,0002,0005,000A,0015.
// - Reset or command[6] pulse mid-burst -> TVALID=0 next cycle, sample_count=0, busy=0, state IDLE.
// - TRAFFIC_GEN_TLAST_EN defined, BURST_LEN 3 -> TLAST=1 only on the 3rd sample; 0 with BURST_LEN 0.

Source files
------------

// File: rtl/traffic_gen_stream.sv
// ---------------------------------------------------------------------------------------------
// traffic_gen_stream
//
// Single-lane AXI-Stream traffic generator. Produces ramp, constant, LFSR or alternating sample
// patterns in bursts of BURST_LEN samples. Each accepted sample can be followed by a
// programmable number of idle cycles. Four of these feed one lane aligner to build a
// 128-bit word.
//
// Parameters
//   DATA_WIDTH  sample width; pattern arithmetic wraps mod 2^DATA_WIDTH
//   INIT_VALUE  first sample for ramp / constant / alternating modes
//   LFSR_SEED   first sample for LFSR mode (a zero seed is replaced by 1)
//   BURST_LEN   samples per burst; 0 runs until stopped
//
// Ports
//   aclk             in   clock, rising edge
//   reset            in   synchronous, active-high
//   command          in   [0] run, [6] soft reset, [8:7] mode, [23:16] gap cycles
//   M00_AXIS_TVALID  out  sample valid
//   M00_AXIS_TDATA   out  sample
//   M00_AXIS_TREADY  in   downstream ready
//   M00_AXIS_TLAST   out  final sample of a burst (only with TRAFFIC_GEN_TLAST_EN)
//   sample_count     out  handshakes completed in the current / last burst
//   busy             out  sending or in an inter-sample gap
//   done             out  burst finished, waiting for run to drop
//
// Build option
//   TRAFFIC_GEN_TLAST_EN  when defined, adds the M00_AXIS_TLAST output.
// ---------------------------------------------------------------------------------------------
module traffic_gen_stream #(
    parameter int unsigned           DATA_WIDTH = 14,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    parameter logic [DATA_WIDTH-1:0] LFSR_SEED  = {{(DATA_WIDTH-1){1'b0}}, 1'b1},
    parameter logic [31:0]           BURST_LEN  = 32'd1024
) (
    input  logic                  aclk,
    input  logic                  reset,
    input  logic [31:0]           command,
    output logic                  M00_AXIS_TVALID,
    output logic [DATA_WIDTH-1:0] M00_AXIS_TDATA,
    input  logic                  M00_AXIS_TREADY,
`ifdef TRAFFIC_GEN_TLAST_EN
    output logic                  M00_AXIS_TLAST,
`endif
    output logic [31:0]           sample_count,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StGap,
        StDone
    } state_e;

    localparam logic [1:0] ModeRamp  = 2'b00;
    localparam logic [1:0] ModeConst = 2'b01;
    localparam logic [1:0] ModeLfsr  = 2'b10;
    localparam logic [1:0] ModeAlt   = 2'b11;

    // A zero seed would lock the LFSR at zero forever.
    localparam logic [DATA_WIDTH-1:0] SeedEff =
        (LFSR_SEED == '0) ? {{(DATA_WIDTH-1){1'b0}}, 1'b1} : LFSR_SEED;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [31:0]             count_q, count_d;
    logic [1:0]              mode_q, mode_d;
    logic [7:0]              gap_q, gap_d;
    logic [7:0]              gap_cnt_q, gap_cnt_d;
    logic                    run_q;

    logic                    soft_rst;
    logic                    run;
    logic                    start;
    logic                    stop;
    logic                    handshake;
    logic                    last_beat;
    logic [31:0]             count_inc;

    // Command bits with no function in this block.
    logic                    unused_cmd;
    assign unused_cmd = ^{command[31:24], command[15:9], command[5:1]};

    // ---------------------------------------------------------------------------------------
    // Control decode
    // ---------------------------------------------------------------------------------------
    assign soft_rst  = reset | command[6];
    assign run       = command[0];
    assign start     = run & ~run_q;
    assign stop      = ~run;
    assign handshake = (state_q == StSend) & M00_AXIS_TREADY;

    // Saturating increment; only reachable with an unbounded burst.
    assign count_inc = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;

    // The sample currently on the bus is the last of the burst. A saturated counter wraps
    // to zero here, which never equals a non-zero BURST_LEN.
    assign last_beat = (BURST_LEN != 32'd0) && ((count_q + 32'd1) == BURST_LEN);

    function automatic logic [DATA_WIDTH-1:0] next_sample(input logic [DATA_WIDTH-1:0] d,
                                                          input logic [1:0]            m);
        logic [DATA_WIDTH-1:0] n;
        n = d;
        unique case (m)
            ModeRamp:  n = d + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
            ModeConst: n = d;
            ModeLfsr:  n = {d[DATA_WIDTH-2:0],
                            d[DATA_WIDTH-1] ^ d[DATA_WIDTH-2] ^ d[DATA_WIDTH-3] ^ d[1]};
            ModeAlt:   n = ~d;
            default:   n = d;
        endcase
        return n;
    endfunction

    // ---------------------------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (soft_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSend;
                end
            end
            StSend: begin
                // Stop is only honoured on a handshake so TVALID is never withdrawn.
                if (handshake) begin
                    if (last_beat) begin
                        state_d = StDone;
                    end else if (stop) begin
                        state_d = StIdle;
                    end else if (gap_q != 8'd0) begin
                        state_d = StGap;
                    end
                end
            end
            StGap: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (gap_cnt_q <= 8'd1) begin
                    state_d = StSend;
                end
            end
            StDone: begin
                if (stop) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------------------------------
    // Datapath next state
    // ---------------------------------------------------------------------------------------
    always_comb begin
        data_d    = data_q;
        count_d   = count_q;
        mode_d    = mode_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        unique case (state_q)
            StIdle: begin
                // Mode and gap are captured once per burst.
                if (start) begin
                    mode_d  = command[8:7];
                    gap_d   = command[23:16];
                    data_d  = (command[8:7] == ModeLfsr) ? SeedEff : INIT_VALUE;
                    count_d = 32'd0;
                end
            end
            StSend: begin
                if (handshake) begin
                    count_d   = count_inc;
                    data_d    = next_sample(data_q, mode_q);
                    gap_cnt_d = gap_q;
                end
            end
            StGap: begin
                if (gap_cnt_q != 8'd0) begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            StDone: begin
            end
            default: begin
            end
        endcase
    end

    // ---------------------------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (soft_rst) begin
            data_q    <= '0;
            count_q   <= 32'd0;
            mode_q    <= ModeRamp;
            gap_q     <= 8'd0;
            gap_cnt_q <= 8'd0;
            run_q     <= 1'b0;
        end else begin
            data_q    <= data_d;
            count_q   <= count_d;
            mode_q    <= mode_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            run_q     <= run;
        end
    end

    // ---------------------------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------------------------
    always_comb begin
        M00_AXIS_TVALID = (state_q == StSend);
        M00_AXIS_TDATA  = data_q;
        sample_count    = count_q;
        busy            = (state_q == StSend) || (state_q == StGap);
        done            = (state_q == StDone);
    end

`ifdef TRAFFIC_GEN_TLAST_EN
    // count_q is frozen while a sample waits for TREADY, so TLAST holds with TDATA.
    always_comb begin
        M00_AXIS_TLAST = (state_q == StSend) && last_beat;
    end
`endif

endmodule

// File: tb/tb_traffic_gen_stream.sv
module tb_traffic_gen_stream;

    localparam logic [13:0] Init0 = 14'h0000;
    localparam logic [13:0] Init1 = 14'h3FFE;
    localparam logic [13:0] Init2 = 14'h0000;
    localparam logic [13:0] Seed0 = 14'h0001;
    localparam logic [13:0] Seed1 = 14'h0000;
    localparam logic [13:0] Seed2 = 14'h0001;
    localparam logic [31:0] Bl0   = 32'd4;
    localparam logic [31:0] Bl1   = 32'd6;
    localparam logic [31:0] Bl2   = 32'd0;

    logic        aclk = 1'b0;
    logic        reset;
    logic [31:0] command;
    logic        tready;

    logic        tvalid [3];
    logic [13:0] tdata  [3];
    logic [31:0] scount [3];
    logic        busy   [3];
    logic        done   [3];
`ifdef TRAFFIC_GEN_TLAST_EN
    logic        tlast  [3];
`endif

    always #5 aclk = ~aclk;

    traffic_gen_stream #(.DATA_WIDTH(14), .INIT_VALUE(Init0), .LFSR_SEED(Seed0), .BURST_LEN(Bl0))
    dut0 (
        .aclk(aclk), .reset(reset), .command(command),
        .M00_AXIS_TVALID(tvalid[0]), .M00_AXIS_TDATA(tdata[0]), .M00_AXIS_TREADY(tready),
`ifdef TRAFFIC_GEN_TLAST_EN
        .M00_AXIS_TLAST(tlast[0]),
`endif
        .sample_count(scount[0]), .busy(busy[0]), .done(done[0])
    );

    traffic_gen_stream #(.DATA_WIDTH(14), .INIT_VALUE(Init1), .LFSR_SEED(Seed1), .BURST_LEN(Bl1))
    dut1 (
        .aclk(aclk), .reset(reset), .command(command),
        .M00_AXIS_TVALID(tvalid[1]), .M00_AXIS_TDATA(tdata[1]), .M00_AXIS_TREADY(tready),
`ifdef TRAFFIC_GEN_TLAST_EN
        .M00_AXIS_TLAST(tlast[1]),
`endif
        .sample_count(scount[1]), .busy(busy[1]), .done(done[1])
    );

    traffic_gen_stream #(.DATA_WIDTH(14), .INIT_VALUE(Init2), .LFSR_SEED(Seed2), .BURST_LEN(Bl2))
    dut2 (
        .aclk(aclk), .reset(reset), .command(command),
        .M00_AXIS_TVALID(tvalid[2]), .M00_AXIS_TDATA(tdata[2]), .M00_AXIS_TREADY(tready),
`ifdef TRAFFIC_GEN_TLAST_EN
        .M00_AXIS_TLAST(tlast[2]),
`endif
        .sample_count(scount[2]), .busy(busy[2]), .done(done[2])
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: whether a sample is offered, idle cycles left, burst finished,
    // handshakes so far, and the settings captured at the start of the burst.
    bit          m_valid [3];
    int          m_gap_left [3];
    bit          m_done [3];
    int unsigned m_cnt [3];
    logic [1:0]  m_mode [3];
    int          m_gap [3];
    bit          m_prev [3];

    logic [13:0] acc0 [$];
    logic [13:0] acc1 [$];
    logic [13:0] acc2 [$];

    function automatic logic [13:0] init_of(input int i);
        return (i == 0) ? Init0 : (i == 1) ? Init1 : Init2;
    endfunction

    function automatic logic [13:0] seed_of(input int i);
        return (i == 0) ? Seed0 : (i == 1) ? Seed1 : Seed2;
    endfunction

    function automatic int unsigned bl_of(input int i);
        return (i == 0) ? Bl0 : (i == 1) ? Bl1 : Bl2;
    endfunction

    // k-th sample of a burst, computed directly from the pattern definition.
    function automatic logic [13:0] pattern(input int i, input logic [1:0] mode,
                                            input int unsigned k);
        logic [13:0] d;
        if (mode == 2'b10) d = (seed_of(i) == 14'd0) ? 14'h0001 : seed_of(i);
        else               d = init_of(i);
        case (mode)
            2'b00: d = d + k[13:0];
            2'b01: begin end
            2'b10: for (int unsigned j = 0; j < k; j++) d = {d[12:0], d[13] ^ d[12] ^ d[11] ^ d[1]};
            default: if (k[0]) d = ~d;
        endcase
        return d;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("tvalid%0d", i), {31'd0, tvalid[i]}, {31'd0, m_valid[i]});
            check($sformatf("busy%0d", i), {31'd0, busy[i]},
                  {31'd0, (m_valid[i] || (m_gap_left[i] > 0))});
            check($sformatf("done%0d", i), {31'd0, done[i]}, {31'd0, m_done[i]});
            check($sformatf("count%0d", i), scount[i], m_cnt[i]);
            if (m_valid[i])
                check($sformatf("tdata%0d", i), {18'd0, tdata[i]},
                      {18'd0, pattern(i, m_mode[i], m_cnt[i])});
`ifdef TRAFFIC_GEN_TLAST_EN
            check($sformatf("tlast%0d", i), {31'd0, tlast[i]},
                  {31'd0, (m_valid[i] && bl_of(i) != 0 && m_cnt[i] + 1 == bl_of(i))});
`endif
        end
    endtask

    task automatic model_update();
        bit start;
        for (int i = 0; i < 3; i++) begin
            if (reset || command[6]) begin
                m_valid[i] = 0; m_gap_left[i] = 0; m_done[i] = 0; m_cnt[i] = 0; m_prev[i] = 0;
            end else begin
                start     = command[0] && !m_prev[i];
                m_prev[i] = command[0];
                if (m_valid[i]) begin
                    if (tready) begin
                        if (m_cnt[i] != 32'hFFFF_FFFF) m_cnt[i]++;
                        if (bl_of(i) != 0 && m_cnt[i] == bl_of(i)) begin
                            m_valid[i] = 0; m_done[i] = 1;
                        end else if (!command[0]) begin
                            m_valid[i] = 0;
                        end else if (m_gap[i] != 0) begin
                            m_valid[i] = 0; m_gap_left[i] = m_gap[i];
                        end
                    end
                end else if (m_gap_left[i] > 0) begin
                    if (!command[0]) m_gap_left[i] = 0;
                    else if (m_gap_left[i] == 1) begin m_gap_left[i] = 0; m_valid[i] = 1; end
                    else m_gap_left[i]--;
                end else if (m_done[i]) begin
                    if (!command[0]) m_done[i] = 0;
                end else if (start) begin
                    m_mode[i] = command[8:7];
                    m_gap[i]  = int'(command[23:16]);
                    m_cnt[i]  = 0;
                    m_valid[i] = 1;
                end
            end
        end
    endtask

    // One clock: check outputs, record handshakes, clock the DUT and the model.
    task automatic cycle();
        check_all();
        if (tvalid[0] && tready) acc0.push_back(tdata[0]);
        if (tvalid[1] && tready) acc1.push_back(tdata[1]);
        if (tvalid[2] && tready) acc2.push_back(tdata[2]);
        @(posedge aclk);
        model_update();
        @(negedge aclk);
    endtask

    logic [13:0] exp_ramp0 [4]  = '{14'h0000, 14'h0001, 14'h0002, 14'h0003};
    logic [13:0] exp_ramp1 [3]  = '{14'h3FFE, 14'h3FFF, 14'h0000};
    logic [13:0] exp_lfsr  [5]  = '{14'h0001, 14'h0002, 14'h0005, 14'h000A, 14'h0015};
    bit          gap_pat   [7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        logic [31:0] cmd;
        logic        run;

        reset   = 1'b1;
        command = 32'd0;
        tready  = 1'b0;
        repeat (2) @(posedge aclk);
        model_update();
        @(negedge aclk);
        for (int i = 0; i < 3; i++) check($sformatf("rst_tdata%0d", i), {18'd0, tdata[i]}, 32'd0);
        cycle();
        reset  = 1'b0;
        tready = 1'b1;
        repeat (2) cycle();

        // Ramp burst: BURST_LEN 4 from 0, BURST_LEN 6 wrapping through 3FFF.
        acc0.delete(); acc1.delete(); acc2.delete();
        command = 32'h0000_0001;
        repeat (8) cycle();
        check("ramp0_len", acc0.size(), 32'd4);
        for (int k = 0; k < 4; k++)
            if (k < acc0.size()) check($sformatf("ramp0_s%0d", k), {18'd0, acc0[k]},
                                       {18'd0, exp_ramp0[k]});
        for (int k = 0; k < 3; k++)
            if (k < acc1.size()) check($sformatf("wrap1_s%0d", k), {18'd0, acc1[k]},
                                       {18'd0, exp_ramp1[k]});
        check("ramp0_done", {31'd0, done[0]}, 32'd1);
        check("ramp0_count", scount[0], 32'd4);
        check("ramp0_tvalid", {31'd0, tvalid[0]}, 32'd0);

        // LFSR: seed 1, and a zero seed replaced by 1.
        command = 32'd0;
        repeat (2) cycle();
        acc0.delete(); acc1.delete(); acc2.delete();
        command = 32'h0000_0101;
        repeat (7) cycle();
        check("lfsr2_len", acc2.size(), 32'd6);
        for (int k = 0; k < 5; k++) begin
            if (k < acc2.size()) check($sformatf("lfsr2_s%0d", k), {18'd0, acc2[k]},
                                       {18'd0, exp_lfsr[k]});
            if (k < acc1.size()) check($sformatf("lfsr1_s%0d", k), {18'd0, acc1[k]},
                                       {18'd0, exp_lfsr[k]});
        end

        // Backpressure on the third sample.
        command = 32'd0;
        repeat (2) cycle();
        command = 32'h0000_0001;
        repeat (3) cycle();
        tready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("bp_tvalid", {31'd0, tvalid[0]}, 32'd1);
            check("bp_tdata", {18'd0, tdata[0]}, 32'd2);
            check("bp_count", scount[0], 32'd2);
            cycle();
        end
        tready = 1'b1;
        repeat (4) cycle();

        // Gap of 2: valid every third cycle.
        command = 32'd0;
        repeat (2) cycle();
        command = 32'h0002_0001;
        cycle();
        for (int k = 0; k < 7; k++) begin
            check($sformatf("gap_v%0d", k), {31'd0, tvalid[0]}, {31'd0, gap_pat[k]});
            cycle();
        end

        // Soft reset, then hard reset, mid-burst.
        command = 32'd0;
        repeat (2) cycle();
        command = 32'h0000_0001;
        repeat (3) cycle();
        command = 32'h0000_0041;
        cycle();
        check("srst_tvalid", {31'd0, tvalid[2]}, 32'd0);
        check("srst_busy", {31'd0, busy[2]}, 32'd0);
        check("srst_count", scount[2], 32'd0);
        command = 32'h0000_0001;
        repeat (3) cycle();
        reset = 1'b1;
        cycle();
        check("hrst_tvalid", {31'd0, tvalid[2]}, 32'd0);
        check("hrst_count", scount[2], 32'd0);
        reset = 1'b0;

        // Randomized traffic against the model.
        run = 1'b0;
        for (int c = 0; c < 2500; c++) begin
            tready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) run = ~run;
            cmd        = $urandom;
            cmd[0]     = run;
            cmd[6]     = ($urandom_range(0, 149) == 0);
            cmd[23:16] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(4, 9))
                                                     : 8'($urandom_range(0, 2));
            command    = cmd;
            reset      = ($urandom_range(0, 299) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
